// File: rtl/u_xmit_arb.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// Optional BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module u_xmit_arb #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_l,
    input  logic [NUM_REQ-1:0]   reqH,
    input  logic [NUM_REQ*8-1:0] req_dataH,
    output logic [NUM_REQ-1:0]   gntH,
    output logic                 xmitH,
    output logic [7:0]           xmit_dataH,
    input  logic                 xmit_doneH,
    output logic                 arb_busyH,
    output logic [ID_W-1:0]      arb_ownerH,
    output logic                 timeoutH
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 xmit_q, xmit_d;
    logic [7:0]           data_q, data_d;
    logic                 busy_q, busy_d;
    logic [ID_W-1:0]      owner_q, owner_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic                 timeout_q, timeout_d;

    logic                 win_found;
    logic [ID_W-1:0]      win_idx;
    logic [7:0]           win_byte;
    logic [NUM_REQ-1:0]   win_gnt;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`else
    logic                 unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
`endif

    // Winner search: indices above last first, then wrap to indices up to last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        win_byte  = 8'h00;
        win_gnt   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_found && reqH[i] && (ID_W'(i) > last_q)) begin
                win_found  = 1'b1;
                win_idx    = ID_W'(i);
                win_byte   = req_dataH[8*i +: 8];
                win_gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_found && reqH[i] && (ID_W'(i) <= last_q)) begin
                win_found  = 1'b1;
                win_idx    = ID_W'(i);
                win_byte   = req_dataH[8*i +: 8];
                win_gnt[i] = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic; pulses default low, data/owner hold.
    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        xmit_d    = 1'b0;
        timeout_d = 1'b0;
        data_d    = data_q;
        busy_d    = busy_q;
        owner_d   = owner_q;
        last_d    = last_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    data_d  = win_byte;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    gnt_d   = win_gnt;
                    xmit_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (xmit_doneH) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            xmit_q    <= 1'b0;
            data_q    <= 8'h00;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            timeout_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            xmit_q    <= xmit_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gntH       = gnt_q;
    assign xmitH      = xmit_q;
    assign xmit_dataH = data_q;
    assign arb_busyH  = busy_q;
    assign arb_ownerH = owner_q;
    assign timeoutH   = timeout_q;

endmodule

// File: tb/tb_u_xmit_arb.sv
// Directed bench for u_xmit_arb: reset, rr order, latency, mid-BUSY reset and watchdog.
module tb_u_xmit_arb;

    logic        sys_clk = 1'b0;
    logic        sys_rst_l;
    logic [3:0]  reqH;
    logic [31:0] req_dataH;
    logic [3:0]  gntH;
    logic        xmitH;
    logic [7:0]  xmit_dataH;
    logic        xmit_doneH;
    logic        arb_busyH;
    logic [1:0]  arb_ownerH;
    logic        timeoutH;

    int checks = 0;
    int errors = 0;

    u_xmit_arb #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYC(16)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_l  (sys_rst_l),
        .reqH       (reqH),
        .req_dataH  (req_dataH),
        .gntH       (gntH),
        .xmitH      (xmitH),
        .xmit_dataH (xmit_dataH),
        .xmit_doneH (xmit_doneH),
        .arb_busyH  (arb_busyH),
        .arb_ownerH (arb_ownerH),
        .timeoutH   (timeoutH)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] g,
                                input logic [1:0] own, input logic [7:0] dat);
        chk({tag, ".gnt"},   32'(gntH), 32'(g));
        chk({tag, ".xmit"},  32'(xmitH), 32'h1);
        chk({tag, ".data"},  32'(xmit_dataH), 32'(dat));
        chk({tag, ".owner"}, 32'(arb_ownerH), 32'(own));
        chk({tag, ".busy"},  32'(arb_busyH), 32'h1);
    endtask

    // Leave START, spend n cycles in BUSY, then pulse done and expect IDLE.
    task automatic finish_byte(input string tag, input int n);
        tick();
        chk({tag, ".start_gnt"},  32'(gntH), 32'h0);
        chk({tag, ".start_xmit"}, 32'(xmitH), 32'h0);
        chk({tag, ".busy_held"},  32'(arb_busyH), 32'h1);
        repeat (n - 1) tick();
        chk({tag, ".busy_wait"}, 32'(arb_busyH), 32'h1);
        xmit_doneH = 1'b1;
        tick();
        xmit_doneH = 1'b0;
        chk({tag, ".busy_clr"}, 32'(arb_busyH), 32'h0);
        chk({tag, ".no_gnt"},   32'(gntH), 32'h0);
    endtask

    initial begin
        sys_rst_l  = 1'b0;
        reqH       = 4'hF;
        req_dataH  = {8'hD3, 8'h5A, 8'hB1, 8'hA0};
        xmit_doneH = 1'b0;

        // Reset held with all requests asserted
        repeat (3) tick();
        chk("rst.gnt",   32'(gntH), 32'h0);
        chk("rst.xmit",  32'(xmitH), 32'h0);
        chk("rst.data",  32'(xmit_dataH), 32'h0);
        chk("rst.busy",  32'(arb_busyH), 32'h0);
        chk("rst.owner", 32'(arb_ownerH), 32'h0);
        chk("rst.tmo",   32'(timeoutH), 32'h0);
        sys_rst_l = 1'b1;

        // Round-robin 0,1,2,3 with requesters dropping on their grant
        tick(); expect_grant("rr0", 4'b0001, 2'd0, 8'hA0); reqH = 4'b1110;
        finish_byte("rr0", 5);
        tick(); expect_grant("rr1", 4'b0010, 2'd1, 8'hB1); reqH = 4'b1100;
        finish_byte("rr1", 5);
        tick(); expect_grant("rr2", 4'b0100, 2'd2, 8'h5A); reqH = 4'b1000;
        finish_byte("rr2", 5);
        tick(); expect_grant("rr3", 4'b1000, 2'd3, 8'hD3); reqH = 4'b0000;
        finish_byte("rr3", 5);
        reqH = 4'hF;
        tick(); expect_grant("rr_wrap", 4'b0001, 2'd0, 8'hA0); reqH = 4'b0000;
        finish_byte("rr_wrap", 5);

        // Single requester 2, done 10 cycles later
        reqH = 4'b0100;
        tick(); expect_grant("single2", 4'b0100, 2'd2, 8'h5A); reqH = 4'b0000;
        finish_byte("single2", 10);

        // After grant to 1, 1010 held -> 3 then 1
        reqH = 4'b0010;
        tick(); expect_grant("pre1", 4'b0010, 2'd1, 8'hB1); reqH = 4'b0000;
        finish_byte("pre1", 3);
        reqH = 4'b1010;
        tick(); expect_grant("held3", 4'b1000, 2'd3, 8'hD3);
        finish_byte("held3", 3);
        tick(); expect_grant("held1", 4'b0010, 2'd1, 8'hB1); reqH = 4'b0000;
        finish_byte("held1", 3);

        // Done pulse in IDLE is ignored
        xmit_doneH = 1'b1;
        tick();
        xmit_doneH = 1'b0;
        chk("idle_done.busy", 32'(arb_busyH), 32'h0);
        chk("idle_done.xmit", 32'(xmitH), 32'h0);
        tick();
        chk("idle_done.gnt", 32'(gntH), 32'h0);

        // Reset asserted while BUSY, then arbitration restarts at 0
        reqH = 4'b0100;
        tick(); expect_grant("pre_rst", 4'b0100, 2'd2, 8'h5A); reqH = 4'b0000;
        tick();
        sys_rst_l = 1'b0;
        #1;
        chk("mid_rst.xmit",  32'(xmitH), 32'h0);
        chk("mid_rst.busy",  32'(arb_busyH), 32'h0);
        chk("mid_rst.owner", 32'(arb_ownerH), 32'h0);
        chk("mid_rst.data",  32'(xmit_dataH), 32'h0);
        tick();
        sys_rst_l = 1'b1;
        reqH = 4'hF;
        tick(); expect_grant("post_rst", 4'b0001, 2'd0, 8'hA0);

        // Watchdog: no done; requester 1 waits behind the stalled byte
        reqH = 4'b0010;
        tick();
        repeat (15) tick();
        chk("wd.pre_tmo", 32'(timeoutH), 32'h0);
        chk("wd.pre_busy", 32'(arb_busyH), 32'h1);
        tick();
`ifdef UART_ARB_TIMEOUT_EN
        chk("wd.tmo",  32'(timeoutH), 32'h1);
        chk("wd.busy", 32'(arb_busyH), 32'h0);
        tick();
        chk("wd.tmo_pulse", 32'(timeoutH), 32'h0);
`else
        chk("wd.tmo",  32'(timeoutH), 32'h0);
        chk("wd.busy", 32'(arb_busyH), 32'h1);
        xmit_doneH = 1'b1;
        tick();
        xmit_doneH = 1'b0;
        chk("wd.done_busy", 32'(arb_busyH), 32'h0);
        tick();
`endif
        expect_grant("wd.next", 4'b0010, 2'd1, 8'hB1);
        reqH = 4'b0000;
        finish_byte("wd.next", 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
